// File: rtl/mirror_seg_driver.sv
// Mirror display driver: sequential double-dabble BCD conversion feeding a 4-digit multiplexed 7-segment scan.
// Optional feature macro MIRROR_LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module mirror_seg_driver #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] Display,
   input  logic [1:0] SS,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       bcd_valid
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD
   } state_e;

   state_e        state_q, state_d;
   logic          first_q, first_d;
   logic [7:0]    dispCap_q, dispCap_d;
   logic [1:0]    ssCap_q, ssCap_d;
   logic [19:0]   shift_q, shift_d;
   logic [19:0]   shiftAdj;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [3:0]    hund_q, hund_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [1:0]    mode_q, mode_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          blankHund, blankTens;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] digitSeg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic logic [6:0] glyphSeg(input logic [1:0] m);
      case (m)
         2'd0:    return 7'b0000111;
         2'd1:    return 7'b0001000;
         2'd2:    return 7'b1001111;
         default: return 7'b0101111;
      endcase
   endfunction

   // Each shift step corrects every BCD nibble >= 5 before moving one binary bit in.
   assign shiftAdj = {add3(shift_q[19:16]), add3(shift_q[15:12]), add3(shift_q[11:8]), shift_q[7:0]};

   always_comb begin
      state_d   = state_q;
      first_d   = first_q;
      dispCap_d = dispCap_q;
      ssCap_d   = ssCap_q;
      shift_d   = shift_q;
      bitCnt_d  = bitCnt_q;
      hund_d    = hund_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      mode_d    = mode_q;
      valid_d   = valid_q;
      case (state_q)
         IDLE: begin
            if (first_q || ({Display, SS} != {dispCap_q, ssCap_q})) begin
               state_d   = SHIFT;
               first_d   = 1'b0;
               dispCap_d = Display;
               ssCap_d   = SS;
               shift_d   = {12'd0, Display};
               bitCnt_d  = 3'd0;
            end
         end
         SHIFT: begin
            shift_d  = {shiftAdj[18:0], 1'b0};
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            hund_d  = shift_q[19:16];
            tens_d  = shift_q[15:12];
            ones_d  = shift_q[11:8];
            mode_d  = ssCap_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MIRROR_LEADING_ZERO_BLANK_EN
   assign blankHund = (hund_d == 4'd0);
   assign blankTens = blankHund && (tens_d == 4'd0);
`else
   assign blankHund = 1'b0;
   assign blankTens = 1'b0;
`endif

   // an/seg are built from next-state values so the enable and its pattern switch on the same edge.
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      digit_d = digit_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         digit_d = digit_q + 2'd1;
      end
      an_d  = ~(4'b0001 << digit_d);
      seg_d = SEG_BLANK;
      if (valid_d) begin
         case (digit_d)
            2'd0:    seg_d = digitSeg(ones_d);
            2'd1:    seg_d = blankTens ? SEG_BLANK : digitSeg(tens_d);
            2'd2:    seg_d = blankHund ? SEG_BLANK : digitSeg(hund_d);
            default: seg_d = glyphSeg(mode_d);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         first_q   <= 1'b1;
         dispCap_q <= 8'd0;
         ssCap_q   <= 2'd0;
         shift_q   <= 20'd0;
         bitCnt_q  <= 3'd0;
         hund_q    <= 4'd0;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
         mode_q    <= 2'd0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         digit_q   <= 2'd0;
         an_q      <= 4'b1111;
         seg_q     <= SEG_BLANK;
      end else begin
         state_q   <= state_d;
         first_q   <= first_d;
         dispCap_q <= dispCap_d;
         ssCap_q   <= ssCap_d;
         shift_q   <= shift_d;
         bitCnt_q  <= bitCnt_d;
         hund_q    <= hund_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         mode_q    <= mode_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign bcd_valid = valid_q;

endmodule

// File: tb/tb_mirror_seg_driver.sv
// Directed self-checking bench for mirror_seg_driver with SCAN_DIV = 4.
// Expected scan position comes from an independent count of clock edges since reset release.
module tb_mirror_seg_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] Display;
   logic [1:0] SS;
   logic [6:0] seg;
   logic [3:0] an;
   logic       bcd_valid;

   int checks = 0;
   int errors = 0;
   int edgeCnt;

   mirror_seg_driver #(.SCAN_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Display   (Display),
      .SS        (SS),
      .seg       (seg),
      .an        (an),
      .bcd_valid (bcd_valid)
   );

   always #5 clk = ~clk;

   // Reference scan position: edges seen since the last reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edgeCnt <= 0;
      else        edgeCnt <= edgeCnt + 1;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [6:0] numSeg(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic logic [6:0] glyph(input int m);
      case (m)
         0:       return 7'b0000111;
         1:       return 7'b0001000;
         2:       return 7'b1001111;
         default: return 7'b0101111;
      endcase
   endfunction

   function automatic logic [6:0] expSeg(input int idx, input int h, input int t, input int o, input int m);
      bit bh, bt;
`ifdef MIRROR_LEADING_ZERO_BLANK_EN
      bh = (h == 0);
      bt = bh && (t == 0);
`else
      bh = 1'b0;
      bt = 1'b0;
`endif
      case (idx)
         0:       return numSeg(o);
         1:       return bt ? 7'b1111111 : numSeg(t);
         2:       return bh ? 7'b1111111 : numSeg(h);
         default: return glyph(m);
      endcase
   endfunction

   task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic stepClocks(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s);
      Display = d;
      SS      = s;
   endtask

   task automatic checkOutput(input string tag, input int h, input int t, input int o, input int m, input bit valid);
      int idx;
      logic [6:0] es;
      idx = (edgeCnt / 4) % 4;
      es  = valid ? expSeg(idx, h, t, o, m) : 7'b1111111;
      checkVal({tag, ".an"}, {4'd0, an}, {4'd0, ~(4'b0001 << idx)});
      checkVal({tag, ".seg"}, {1'b0, seg}, {1'b0, es});
      checkVal({tag, ".valid"}, {7'd0, bcd_valid}, {7'd0, valid});
   endtask

   task automatic scanCheck(input string tag, input int h, input int t, input int o, input int m, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         checkOutput(tag, h, t, o, m, 1'b1);
         stepClocks(1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(8'd0, 2'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("rst.an", {4'd0, an}, 8'h0F);
      checkVal("rst.seg", {1'b0, seg}, 8'h7F);
      checkVal("rst.valid", {7'd0, bcd_valid}, 8'd0);

      // First conversion after release: 000 't'
      rst_n = 1'b1;
      stepClocks(9);
      checkOutput("first.pre", 0, 0, 0, 0, 1'b0);
      stepClocks(1);
      checkOutput("first.load", 0, 0, 0, 0, 1'b1);
      scanCheck("first.scan", 0, 0, 0, 0, 16);

      // Upper boundary 255 with 'r'
      applyStimulus(8'd255, 2'd3);
      stepClocks(9);
      checkOutput("d255.pre", 0, 0, 0, 0, 1'b1);
      stepClocks(1);
      scanCheck("d255.scan", 2, 5, 5, 3, 16);

      // Input change during SHIFT is deferred to a second conversion
      applyStimulus(8'd42, 2'd1);
      stepClocks(3);
      applyStimulus(8'd137, 2'd1);
      stepClocks(2);
      checkOutput("d42.mid", 2, 5, 5, 3, 1'b1);
      stepClocks(5);
      checkOutput("d42.load", 0, 4, 2, 1, 1'b1);
      stepClocks(9);
      checkOutput("d137.pre", 0, 4, 2, 1, 1'b1);
      stepClocks(1);
      scanCheck("d137.scan", 1, 3, 7, 1, 8);

      // Leading zeros, 'I' glyph
      applyStimulus(8'd7, 2'd2);
      stepClocks(10);
      scanCheck("d7.scan", 0, 0, 7, 2, 16);

      // Reset asserted mid-SHIFT acts immediately and discards the old digits
      applyStimulus(8'd99, 2'd0);
      stepClocks(3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkVal("midrst.an", {4'd0, an}, 8'h0F);
      checkVal("midrst.seg", {1'b0, seg}, 8'h7F);
      checkVal("midrst.valid", {7'd0, bcd_valid}, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stepClocks(4);
      checkOutput("midrst.blank", 0, 0, 0, 0, 1'b0);
      stepClocks(5);
      checkOutput("midrst.pre", 0, 0, 0, 0, 1'b0);
      stepClocks(1);
      scanCheck("d99.scan", 0, 9, 9, 0, 16);

      // SS-only change re-converts without dropping valid
      applyStimulus(8'd99, 2'd1);
      stepClocks(5);
      checkOutput("ss.mid", 0, 9, 9, 0, 1'b1);
      stepClocks(5);
      scanCheck("ss.scan", 0, 9, 9, 1, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mirror_seg_driver.md
MIRROR_SEG_DRIVER -- requirements
Module: mirror_seg_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving clocks per digit-scan step (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all flops are on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port Display, input, 8 bits, the unsigned value selected by the mirror data mux.
REQ-005 SHALL have port SS, input, 2 bits, the mux select: 0 Temperature, 1 Avg_mpg, 2 Instant_mpg, 3 Miles_remaining.
REQ-006 SHALL have port seg, output, 7 bits, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-007 SHALL have port an, output, 4 bits, active-low digit enables: an[0] ones, an[1] tens, an[2] hundreds, an[3] mode glyph.
REQ-008 SHALL have port bcd_valid, output, 1 bit, high while the digit registers hold a completed conversion.

Function
REQ-009 SHALL treat Display and SS as synchronous to clk, with no input synchronizer.
REQ-010 SHALL convert Display to 3 BCD digits sequentially by shift-add-3 (double dabble), one shift per clock.
REQ-011 SHALL use converter FSM IDLE -> SHIFT (exactly 8 cycles) -> LOAD (1 cycle) -> IDLE.
REQ-012 SHALL leave IDLE when {Display,SS} differs from the last captured pair, or on the first cycle after reset; it captures {Display,SS} at that exit.
REQ-013 SHALL ignore input changes during SHIFT/LOAD; a change still pending on return to IDLE starts a new conversion the next cycle.
REQ-014 SHALL update the hundreds, tens, ones and mode registers together in LOAD; latency from a captured input to the new registers is 10 clocks.
REQ-015 SHALL hold bcd_valid low from reset until the first LOAD and high thereafter; re-conversions do not drop it.
REQ-016 SHALL run a scan counter 0..SCAN_DIV-1 that wraps; on wrap, the digit index advances 0->1->2->3->0.
REQ-017 SHALL drive an as one-hot-low of the digit index, with seg for that digit in the same cycle (registered, no ghost cycle).
REQ-018 SHALL encode digits 0-9 as standard 7-segment patterns (0 = 1000000, 1 = 1111001, 8 = 0000000).
REQ-019 SHALL show a mode glyph on digit 3 per SS: 0 't' = 0000111, 1 'A' = 0001000, 2 'I' = 1001111, 3 'r' = 0101111.
REQ-020 SHALL drive all 7 segments of a digit high (blank) while bcd_valid is low.
REQ-021 SHALL cover the boundary values: Display 0 gives 0/0/0 and Display 255 gives 2/5/5; no overflow, since 3 digits suffice.

Reset
REQ-022 SHALL, while rst_n is low, force an = 1111, seg = 1111111, bcd_valid = 0, FSM = IDLE, scan counter = 0, digit index = 0, and BCD and captured registers = 0.
REQ-023 SHALL abort any conversion asserted mid-reset; no partial result reaches the digit registers.

Configuration
REQ-024 SHALL, with macro MIRROR_LEADING_ZERO_BLANK_EN defined, blank a hundreds digit of 0, and also a tens digit of 0 when hundreds is 0; ones and the glyph always show.
REQ-025 SHALL, with MIRROR_LEADING_ZERO_BLANK_EN undefined, show all three numeric digits including leading zeros.

Verification (SCAN_DIV = 4)
REQ-026 SHALL pass: release reset with Display = 0 and SS = 0 -> bcd_valid rises 10 clocks after release; the scan shows 0,0,0,'t'.
REQ-027 SHALL pass: Display = 255, SS = 3 -> after 10 clocks, the digits are 5 (an = 1110), 5 (1101), 2 (1011), 'r' 0101111 (0111); each is held for 4 clocks.
REQ-028 SHALL pass: Display 42 -> 137 during SHIFT -> the first LOAD shows 042, then the second conversion starts the next cycle and shows 137 10 clocks later.
REQ-029 SHALL pass: rst_n low mid-SHIFT -> outputs take reset values immediately (asynchronously); the old digits never reappear.
REQ-030 SHALL pass: Display = 7 with MIRROR_LEADING_ZERO_BLANK_EN defined -> an[2] and an[1] show 1111111 and an[0] shows 1111000; without the macro, 1000000, 1000000 and 1111000.
